ram_sp_be_init: RTL and testbench



---
 rtl/ram_sp_be_init_if.sv | 36 +++
 rtl/ram_sp_be_init.sv | 147 ++++++++++++++
 tb/tb_ram_sp_be_init.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_be_init_if.sv
//------------------------------------------------------------------------------
// Module      : ram_sp_be_init_if
// Description : Access bus for ram_sp_be_init (requests, init control, read data)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_sp_be_init_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int c_NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  init_req;
    logic                  busy;
    logic                  we;
    logic [c_NB-1:0]       be;
    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] d;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;

    modport master (
        output init_req, we, be, re, addr, d,
        input  busy, q, q_valid
    );

    modport slave (
        input  init_req, we, be, re, addr, d,
        output busy, q, q_valid
    );
endinterface

`default_nettype wire

// File: rtl/ram_sp_be_init.sv
//------------------------------------------------------------------------------
// Module      : ram_sp_be_init
// Description : Single-port RAM with byte enables, read strobe/valid, selectable
//               read-during-write, optional output register and init sweep
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_sp_be_init #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 10,
    parameter int                  BYTE_WIDTH = 8,
    parameter int                  RDW_MODE   = 0,
    parameter int                  OUT_REG    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input wire              clk,
    input wire              reset_n,
    ram_sp_be_init_if.slave bus
);

    localparam int                    c_NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int                    c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
        $fatal(1, "ram_sp_be_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_busy;
    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The sweep stops on the terminal address instead of wrapping the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (bus.init_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            ST_RUN: begin
                if (bus.init_req) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_busy   = (r_state == ST_INIT);
    assign w_wr     = !w_busy && bus.we;
    assign w_rd     = !w_busy && bus.re;
    assign w_old    = r_mem[bus.addr];
    assign bus.busy = w_busy;

    for (genvar i = 0; i < c_NB; i++) begin : g_lane
        assign w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = (bus.we && bus.be[i])
            ? bus.d[i*BYTE_WIDTH +: BYTE_WIDTH]
            : w_old[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // Array is deliberately outside the reset domain; the sweep provides known contents.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= INIT_VALUE;
        end else if (w_wr) begin
            r_mem[bus.addr] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd;
            if (w_rd) begin
                r_s1_data <= (RDW_MODE != 0) ? w_merged : w_old;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign bus.q       = r_s2_data;
        assign bus.q_valid = r_s2_valid;
    end else begin : g_no_out_reg
        assign bus.q       = r_s1_data;
        assign bus.q_valid = r_s1_valid;
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_sp_be_init.sv
//------------------------------------------------------------------------------
// Module      : tb_ram_sp_be_init
// Description : Scoreboard bench; dut0 = old-data RDW with output register,
//               dut1 = merged-data RDW without output register
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_sp_be_init;

    localparam int          c_DW    = 32;
    localparam int          c_AW    = 4;
    localparam int          c_BW    = 8;
    localparam int          c_NB    = 4;
    localparam int          c_DEPTH = 16;
    localparam logic [31:0] c_IV    = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_req = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  be = '0;
    logic [3:0]  addr = '0;
    logic [31:0] d = '0;

    logic [31:0] model [c_DEPTH];
    exp_t        sb0[$];
    exp_t        sb1[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_sp_be_init_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .BYTE_WIDTH(c_BW)) bus0 ();
    ram_sp_be_init_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .BYTE_WIDTH(c_BW)) bus1 ();

    assign bus0.init_req = init_req;
    assign bus0.we       = we;
    assign bus0.re       = re;
    assign bus0.be       = be;
    assign bus0.addr     = addr;
    assign bus0.d        = d;
    assign bus1.init_req = init_req;
    assign bus1.we       = we;
    assign bus1.re       = re;
    assign bus1.be       = be;
    assign bus1.addr     = addr;
    assign bus1.d        = d;

    ram_sp_be_init #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .BYTE_WIDTH(c_BW),
        .RDW_MODE(0), .OUT_REG(1), .INIT_VALUE(c_IV)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
    );

    ram_sp_be_init #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .BYTE_WIDTH(c_BW),
        .RDW_MODE(1), .OUT_REG(0), .INIT_VALUE(c_IV)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
    );

    // Response checkers: each completed read must match the head of its queue on its due cycle.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (reset_n) begin
            if (bus0.q_valid === 1'b1) begin
                checks++;
                if (sb0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0_unexpected_valid q=%h cycle=%0d, no read outstanding", bus0.q, cyc);
                end else begin
                    e = sb0.pop_front();
                    if (bus0.q !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL dut0_read q=%h cycle=%0d, expected q=%h cycle=%0d", bus0.q, cyc, e.data, e.due);
                    end
                end
            end else if (sb0.size() != 0 && sb0[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL dut0_missing_valid q_valid=%b cycle=%0d, expected q=%h at cycle %0d", bus0.q_valid, cyc, sb0[0].data, sb0[0].due);
                void'(sb0.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (reset_n) begin
            if (bus1.q_valid === 1'b1) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected_valid q=%h cycle=%0d, no read outstanding", bus1.q, cyc);
                end else begin
                    e = sb1.pop_front();
                    if (bus1.q !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL dut1_read q=%h cycle=%0d, expected q=%h cycle=%0d", bus1.q, cyc, e.data, e.due);
                    end
                end
            end else if (sb1.size() != 0 && sb1[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL dut1_missing_valid q_valid=%b cycle=%0d, expected q=%h at cycle %0d", bus1.q_valid, cyc, sb1[0].data, sb1[0].due);
                void'(sb1.pop_front());
            end
        end
    end

    // One RUN-state access; called at a falling edge, returns at the next falling edge.
    task automatic access(input logic w, input logic r, input logic [3:0] b,
                          input logic [3:0] a, input logic [31:0] dd);
        logic [31:0] old_w;
        logic [31:0] mrg_w;
        we = w; re = r; be = b; addr = a; d = dd;
        old_w = model[a];
        mrg_w = old_w;
        for (int i = 0; i < c_NB; i++) begin
            if (w && b[i]) mrg_w[i*c_BW +: c_BW] = dd[i*c_BW +: c_BW];
        end
        if (r) begin
            sb0.push_back('{data: old_w, due: cyc + 2});
            sb1.push_back('{data: mrg_w, due: cyc + 1});
        end
        if (w) model[a] = mrg_w;
        @(negedge clk);
        we = 1'b0; re = 1'b0; be = '0;
    endtask

    // Counts busy cycles from now, pulsing ignored we/re at busy cycle 5.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100 && bus0.busy === 1'b1; k++) begin
            n++;
            if (k == 5) begin
                we = 1'b1; re = 1'b1; be = 4'hF; addr = 4'd0; d = 32'hFFFFFFFF;
            end else begin
                we = 1'b0; re = 1'b0; be = '0;
            end
            @(negedge clk);
        end
        we = 1'b0; re = 1'b0; be = '0;
        for (int i = 0; i < c_DEPTH; i++) model[i] = c_IV;
    endtask

    task automatic read_all();
        for (int a = 0; a < c_DEPTH; a++) access(1'b0, 1'b1, 4'h0, 4'(a), 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.q !== 32'h0 || bus0.q_valid !== 1'b0 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_dut0 q=%h q_valid=%b busy=%b, expected 0/0/1", bus0.q, bus0.q_valid, bus0.busy);
        end
        checks++;
        if (bus1.q !== 32'h0 || bus1.q_valid !== 1'b0 || bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_dut1 q=%h q_valid=%b busy=%b, expected 0/0/1", bus1.q, bus1.q_valid, bus1.busy);
        end
    endtask

    task automatic test_init_after_reset();
        int n;
        reset_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_busy_len busy_cycles=%0d, expected 16", n);
        end
        checks++;
        if (bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL init_busy_dut1 busy=%b, expected 0", bus1.busy);
        end
        read_all();
    endtask

    task automatic test_byte_enable();
        access(1'b1, 1'b0, 4'b0101, 4'd3, 32'h11223344);
        access(1'b0, 1'b1, 4'b0000, 4'd3, 32'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (model[3] !== 32'hA522A544) begin
            errors++;
            $display("FAIL be_model word=%h, expected a522a544", model[3]);
        end
    endtask

    task automatic test_rdw();
        access(1'b1, 1'b0, 4'hF, 4'd5, 32'h0);
        access(1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
        access(1'b0, 1'b1, 4'h0, 4'd5, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 4; a++) access(1'b1, 1'b0, 4'hF, 4'(a), 32'h1000_0001 * (a + 1));
        for (int a = 0; a < 4; a++) access(1'b0, 1'b1, 4'h0, 4'(a), 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_init_req();
        int n;
        access(1'b1, 1'b0, 4'hF, 4'd7, 32'hCAFEF00D);
        access(1'b1, 1'b0, 4'b0011, 4'd9, 32'h0BADC0DE);
        init_req = 1'b1;
        access(1'b0, 1'b1, 4'h0, 4'd7, 32'h0);
        init_req = 1'b0;
        count_busy(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_req_busy_len busy_cycles=%0d, expected 16", n);
        end
        read_all();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        access(1'b1, 1'b0, 4'hF, 4'd2, 32'h12345678);
        access(1'b0, 1'b1, 4'h0, 4'd2, 32'h0);
        repeat (4) @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus0.q !== 32'h0 || bus0.q_valid !== 1'b0 || bus1.q !== 32'h0 || bus1.q_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset q0=%h v0=%b q1=%h v1=%b, expected all 0",
                     bus0.q, bus0.q_valid, bus1.q, bus1.q_valid);
        end
        repeat (2) @(negedge clk);
        sb0.delete();
        sb1.delete();
        reset_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL resweep_busy_len busy_cycles=%0d, expected 16", n);
        end
        read_all();
    endtask

    initial begin
        for (int i = 0; i < c_DEPTH; i++) model[i] = 32'h0;
        test_reset();
        test_init_after_reset();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_init_req();
        test_reset_mid_sweep();
        repeat (4) @(negedge clk);
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding0=%0d outstanding1=%0d, expected 0/0", sb0.size(), sb1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
